// File: rtl/mux41_arb_pkg.sv
// Shared types and constants for the four-way round-robin mux arbiter.
package mux41_arb_pkg;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_e;
  localparam int N_REQ = 4;
  localparam int IDX_W = 2;
endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set candidate bit at or above ptr_i, wrapping modulo N_REQ.
module rr_pick
  import mux41_arb_pkg::*;
(
  input  logic [N_REQ-1:0] cand_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] win_o,
  output logic             any_o
);

  // Scan from farthest to nearest so the closest set bit to the pointer wins.
  always_comb begin
    win_o = ptr_i;
    any_o = |cand_i;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (cand_i[ptr_i + IDX_W'(i)]) begin
        win_o = ptr_i + IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/mux41_rr_arb.sv
// Round-robin arbiter driving the mux41 select lines; grants are held until release or hold limit.
module mux41_rr_arb
  import mux41_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             i_CLK,
  input  logic             i_RST_N,
  input  logic [N_REQ-1:0] i_REQ,
  output logic [N_REQ-1:0] o_GNT,
  output logic             o_SEL0,
  output logic             o_SEL1,
  output logic             o_BUSY
);

  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_HOLD);

  arb_state_e       state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] sel_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N_REQ-1:0] gnt_q;

  logic             owner_req;
  logic             timeout;
  logic [N_REQ-1:0] owner_oh;
  logic [N_REQ-1:0] cand;
  logic [IDX_W-1:0] win;
  logic             any;
  logic             new_grant;

  // sel_q doubles as the owner index; it only changes on a new grant.
  assign owner_oh  = N_REQ'(1) << sel_q;
  assign owner_req = |(i_REQ & owner_oh);
  assign timeout   = (state_q == GRANT) && owner_req && (cnt_q == MAX_CNT);
  assign cand      = timeout ? (i_REQ & ~owner_oh) : i_REQ;
  assign new_grant = any && ((state_q == IDLE) || !owner_req || timeout);

  rr_pick u_pick (
    .cand_i (cand),
    .ptr_i  (ptr_q),
    .win_o  (win),
    .any_o  (any)
  );

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
    end else if (new_grant) begin
      state_q <= GRANT;
      ptr_q   <= win + IDX_W'(1);
      sel_q   <= win;
      cnt_q   <= CNT_W'(1);
      gnt_q   <= N_REQ'(1) << win;
    end else if (state_q == GRANT) begin
      if (!owner_req) begin
        state_q <= IDLE;
        gnt_q   <= '0;
      end else if (timeout) begin
        cnt_q <= CNT_W'(1);
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign o_GNT  = gnt_q;
  assign o_SEL0 = sel_q[0];
  assign o_SEL1 = sel_q[1];
  assign o_BUSY = (state_q == GRANT);

endmodule

// File: tb/tb_mux41_rr_arb.sv
// Directed bench for mux41_rr_arb with an owner/pointer/counter reference model checked every cycle.
module tb_mux41_rr_arb;

  localparam int HOLD = 2;

  logic       i_CLK;
  logic       i_RST_N;
  logic [3:0] i_REQ;
  logic [3:0] o_GNT;
  logic       o_SEL0;
  logic       o_SEL1;
  logic       o_BUSY;

  int n_tests = 0;
  int n_fail  = 0;

  mux41_rr_arb #(.MAX_HOLD(HOLD)) dut (
    .i_CLK   (i_CLK),
    .i_RST_N (i_RST_N),
    .i_REQ   (i_REQ),
    .o_GNT   (o_GNT),
    .o_SEL0  (o_SEL0),
    .o_SEL1  (o_SEL1),
    .o_BUSY  (o_BUSY)
  );

  // clock / reset
  initial i_CLK = 1'b0;
  always #5 i_CLK = ~i_CLK;

  // reference model: owner index (-1 = nobody), pointer, hold count, last select
  int m_owner;
  int m_ptr;
  int m_cnt;
  int m_sel;

  function automatic int pick(logic [3:0] v, int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic give(int w);
    m_owner = w;
    m_ptr   = (w + 1) % 4;
    m_cnt   = 1;
    m_sel   = w;
  endtask

  always @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      m_owner = -1;
      m_ptr   = 0;
      m_cnt   = 0;
      m_sel   = 0;
    end else if (m_owner < 0) begin
      if (i_REQ != 4'b0000) give(pick(i_REQ, m_ptr));
    end else if (!i_REQ[m_owner]) begin
      if (i_REQ != 4'b0000) give(pick(i_REQ, m_ptr));
      else m_owner = -1;
    end else if (m_cnt == HOLD) begin
      logic [3:0] others;
      others = i_REQ;
      others[m_owner] = 1'b0;
      if (others != 4'b0000) give(pick(others, m_ptr));
      else m_cnt = 1;
    end else begin
      m_cnt++;
    end
  end

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // compare process: every falling edge, DUT outputs vs model
  always @(negedge i_CLK) begin
    logic [3:0] e_gnt;
    logic [1:0] e_sel;
    e_gnt = 4'b0000;
    if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
    e_sel = 2'(m_sel);
    chk("model_gnt",  {4'b0, o_GNT}, {4'b0, e_gnt});
    chk("model_sel",  {6'b0, o_SEL1, o_SEL0}, {6'b0, e_sel});
    chk("model_busy", {7'b0, o_BUSY}, {7'b0, (m_owner >= 0)});
  end

  // driver: apply a request vector, let one edge sample it, settle 2 ns after
  task automatic cycle(logic [3:0] r);
    i_REQ = r;
    @(posedge i_CLK);
    #2;
  endtask

  task automatic do_reset();
    i_RST_N = 1'b0;
    @(posedge i_CLK);
    #2;
    i_RST_N = 1'b1;
  endtask

  task automatic expect_out(string name, logic [3:0] g, logic [1:0] s, logic b);
    chk({name, "_gnt"},  {4'b0, o_GNT}, {4'b0, g});
    chk({name, "_sel"},  {6'b0, o_SEL1, o_SEL0}, {6'b0, s});
    chk({name, "_busy"}, {7'b0, o_BUSY}, {7'b0, b});
  endtask

  int rot[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

  initial begin
    i_RST_N = 1'b0;
    i_REQ   = 4'b0000;
    repeat (3) @(posedge i_CLK);
    #2;
    i_RST_N = 1'b1;

    // reset and idle
    for (int i = 0; i < 10; i++) begin
      cycle(4'b0000);
      expect_out("idle", 4'b0000, 2'b00, 1'b0);
    end

    // single requester 2 for five cycles, then release; select keeps 10
    for (int i = 0; i < 5; i++) begin
      cycle(4'b0100);
      expect_out("single", 4'b0100, 2'b10, 1'b1);
    end
    cycle(4'b0000);
    expect_out("single_rel", 4'b0000, 2'b10, 1'b0);

    // full contention from a fresh pointer
    do_reset();
    for (int i = 0; i < 9; i++) begin
      logic [3:0] e;
      e = 4'b0001 << rot[i];
      cycle(4'b1111);
      expect_out("rotate", e, 2'(rot[i]), 1'b1);
    end

    // owner 0 reaches the limit and releases on the same edge: release wins
    cycle(4'b0001);
    expect_out("hold_max", 4'b0001, 2'b00, 1'b1);
    cycle(4'b0000);
    expect_out("rel_vs_to", 4'b0000, 2'b00, 1'b0);

    // lone requester 1 keeps its grant across repeated limits
    for (int i = 0; i < 7; i++) begin
      cycle(4'b0010);
      expect_out("no_rival", 4'b0010, 2'b01, 1'b1);
    end
    // pointer stayed at 2, so 2 beats 0
    cycle(4'b0101);
    expect_out("ptr_kept", 4'b0100, 2'b10, 1'b1);

    // owner 3 holds past its limit, then hands over straight to 0
    cycle(4'b1000);
    expect_out("own3", 4'b1000, 2'b11, 1'b1);
    cycle(4'b1000);
    cycle(4'b1000);
    expect_out("own3_to", 4'b1000, 2'b11, 1'b1);
    cycle(4'b0001);
    expect_out("handover", 4'b0001, 2'b00, 1'b1);

    // asynchronous reset while owner 2 is granted
    cycle(4'b0100);
    expect_out("pre_rst", 4'b0100, 2'b10, 1'b1);
    #1;
    i_RST_N = 1'b0;
    #1;
    expect_out("async_rst", 4'b0000, 2'b00, 1'b0);
    i_REQ = 4'b1111;
    @(posedge i_CLK);
    #2;
    i_RST_N = 1'b1;
    cycle(4'b1111);
    expect_out("post_rst", 4'b0001, 2'b00, 1'b1);
    cycle(4'b0000);
    cycle(4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
